mul_acc_stage: RTL



---
 rtl/mac_pkg.sv | 19 +
 rtl/mul_acc_stage_mul.sv | 24 ++
 rtl/mul_acc_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate stage: default widths,
// result length, counter width and the control state encoding.
package mac_pkg;

   localparam int MAC_N     = 8;
   localparam int MAC_M     = 8;
   localparam int MAC_ACC_W = 24;
   localparam int MAC_LEN   = 4;

   // Wide enough to hold the values 0..LEN for the default length.
   localparam int CNT_W = $clog2(MAC_LEN + 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } mac_state_e;

endpackage

// File: rtl/mul_acc_stage_mul.sv
// Unsigned array multiplier: sums the shifted partial products A<<i for
// every set bit of B. Purely combinational.
module Array_MUL_USign #(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic [N-1:0]   A,
   input  logic [M-1:0]   B,
   output logic [N+M-1:0] P
);

   // Accumulate one partial-product row per bit of B.
   always_comb begin
      // NOTE: the default assignment first keeps every path driven (no latch),
      // and blocking '=' is required so each row adds onto the previous one.
      P = '0;
      for (int i = 0; i < M; i++) begin
         if (B[i]) begin
            P = P + ((N + M)'(A) << i);
         end
      end
   end

endmodule

// File: rtl/mul_acc_stage.sv
// Sequential multiply-accumulate stage. Accepts LEN unsigned operand pairs,
// registers each product, sums them into an ACC_W-bit accumulator and holds
// the result on a valid/ready output until it is taken.
// Build option: define MAC_SATURATE_EN to saturate the accumulator at all
// ones on overflow; otherwise it wraps modulo 2^ACC_W. ovf flags either case.
module mul_acc_stage
   import mac_pkg::*;
#(
   parameter int N     = MAC_N,
   parameter int M     = MAC_M,
   parameter int ACC_W = MAC_ACC_W,
   parameter int LEN   = MAC_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     A,
   input  logic [M-1:0]     B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);

   // Package width for the default length, recomputed for any other length.
   localparam int CW = (LEN == MAC_LEN) ? CNT_W : $clog2(LEN + 1);

   if (ACC_W < N + M) begin : g_acc_w_check
      $error("mul_acc_stage: ACC_W (%0d) must be at least N+M (%0d)", ACC_W, N + M);
   end
   if (LEN < 1) begin : g_len_check
      $error("mul_acc_stage: LEN (%0d) must be at least 1", LEN);
   end

   mac_state_e       state;
   logic [CW-1:0]    cnt;
   logic [N+M-1:0]   mult_p;
   logic [N+M-1:0]   prod_q;
   logic             p_vld;
   logic [ACC_W-1:0] acc;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [ACC_W:0]   sum_c;
   logic             accept;
   logic             take;
   logic             last_pair;

   Array_MUL_USign #(
      .N (N),
      .M (M)
   ) u_mul (
      .A (A),
      .B (B),
      .P (mult_p)
   );

   assign accept    = in_valid && in_ready_q;
   assign take      = out_valid_q && out_ready;
   assign last_pair = (cnt == CW'(LEN - 1));

   // One extra bit catches the carry-out that signals overflow.
   assign sum_c = {1'b0, acc} + (ACC_W + 1)'(prod_q);

   // Control: run -> drain (final product still in flight) -> hold result.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state       <= RUN;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (accept && last_pair) begin
                  state      <= DRAIN;
                  in_ready_q <= 1'b0;
               end
            end
            DRAIN: begin
               state       <= HOLD;
               out_valid_q <= 1'b1;
            end
            HOLD: begin
               if (out_ready) begin
                  state       <= RUN;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state       <= RUN;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: capture products, accumulate them, clear when the result is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         p_vld  <= 1'b0;
         prod_q <= '0;
         acc    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         p_vld <= accept;
         if (accept) begin
            prod_q <= mult_p;
            cnt    <= cnt + CW'(1);
         end

         if (take) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
         end else if (p_vld) begin
            if (sum_c[ACC_W]) begin
               ovf_q <= 1'b1;
`ifdef MAC_SATURATE_EN
               acc   <= '1;
`else
               acc   <= sum_c[ACC_W-1:0];
`endif
            end else begin
               acc <= sum_c[ACC_W-1:0];
            end
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign acc_out   = acc;
   assign ovf       = ovf_q;

endmodule
